tros_meas_sequencer: RTL and testbench

TROS_MEAS_SEQUENCER -- requirements
Module: tros_meas_sequencer

---
 rtl/tros_pkg.sv | 27 ++
 rtl/tros_seq_timer.sv | 36 +++
 rtl/tros_meas_sequencer.sv | 156 +++++++++++++++
 tb/tb_tros_meas_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tros_pkg.sv
// tros_pkg: shared definitions for the TROS measurement sequencer.
//   tros_state_e   FSM state encoding used by tros_meas_sequencer.
//   window_log2()  log2 of the gate window for a given base and window_sel.
//   timer_width()  down-counter width; holds W-1 for the largest window_sel.
package tros_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } tros_state_e;

    // window_sel = 3 adds 6 to the base exponent.
    localparam int unsigned WINDOW_SEL_SPAN_LOG2 = 6;

    function automatic int unsigned window_log2(input int unsigned base_log2,
                                                input logic [1:0]  sel);
        return base_log2 + 2 * {30'd0, sel};
    endfunction

    function automatic int unsigned timer_width(input int unsigned base_log2);
        return base_log2 + WINDOW_SEL_SPAN_LOG2 + 1;
    endfunction

endpackage

// File: rtl/tros_seq_timer.sv
// tros_seq_timer: loadable down-counter with zero flag, shared by the
// CLEAR, GATE and SETTLE phases of the sequencer.
// Ports:
//   clk, reset  clock and synchronous active-high reset (count -> 0)
//   ena         count/load enable; low holds the count
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   zero        count is zero; the counter stops there
module tros_seq_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ena) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tros_meas_sequencer.sv
// tros_meas_sequencer: sequences one ring-oscillator frequency measurement:
// clear counters, open a gate window of W = 2^(WINDOW_BASE_LOG2+2*window_sel)
// cycles, wait for the oscillator-side synchronizer to settle, then strobe
// the readout latch. Optionally loops back-to-back.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   ena          global enable; low freezes all state and outputs
//   start        level request for a measurement (only seen in IDLE)
//   continuous   loop measurements back-to-back
//   abort        return to IDLE without completing
//   window_sel   window size select, captured on entry to CLEAR
//   ctr_reset    counter clear, gate counting window, latch readout strobe
//   busy         not IDLE; done pulses with latch
//   meas_count   completed measurements (wraps)
//   overrun      sticky start-while-busy flag
// Configuration: define TROS_SEQ_OVERRUN_EN to enable overrun; otherwise 0.
module tros_meas_sequencer
    import tros_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES     = 2,
    parameter int unsigned WINDOW_BASE_LOG2 = 10,
    parameter int unsigned SETTLE_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic [1:0]  window_sel,
    output logic        ctr_reset,
    output logic        gate,
    output logic        latch,
    output logic        busy,
    output logic        done,
    output logic [15:0] meas_count,
    output logic        overrun
);

    localparam int unsigned CW = timer_width(WINDOW_BASE_LOG2);

    localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    tros_state_e     state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_zero;
    logic [CW-1:0]   win_last;

    tros_seq_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Each phase loads (length-1) on entry, so it lasts exactly its length
    // and the zero flag marks its final cycle.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        win_last = (CW'(1) << window_log2(WINDOW_BASE_LOG2, sel_q)) - CW'(1);

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d  = CLEAR;
                        sel_d    = window_sel;
                        tmr_load = 1'b1;
                        tmr_val  = CLEAR_LAST;
                    end
                end
                CLEAR: begin
                    if (tmr_zero) begin
                        state_d  = GATE;
                        tmr_load = 1'b1;
                        tmr_val  = win_last;
                    end
                end
                GATE: begin
                    if (tmr_zero) begin
                        state_d  = SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LAST;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state_d = LATCH;
                    end
                end
                LATCH: begin
                    if (continuous) begin
                        state_d  = CLEAR;
                        sel_d    = window_sel;
                        tmr_load = 1'b1;
                        tmr_val  = CLEAR_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they
    // line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ctr_reset  <= 1'b0;
            gate       <= 1'b0;
            latch      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            meas_count <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ctr_reset <= (state_d == CLEAR);
            gate      <= (state_d == GATE);
            latch     <= (state_d == LATCH);
            done      <= (state_d == LATCH);
            busy      <= (state_d != IDLE);
            if (state_d == LATCH) begin
                meas_count <= meas_count + 16'd1;
            end
        end
    end

`ifdef TROS_SEQ_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ena && start && state_q != IDLE) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// tb_tros_meas_sequencer: directed bench for tros_meas_sequencer with
// CLEAR_CYCLES=2, WINDOW_BASE_LOG2=4, SETTLE_CYCLES=3.
module tb_tros_meas_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  window_sel = 2'd0;
    logic        ctr_reset, gate, latch, busy, done, overrun;
    logic [15:0] meas_count;

`ifdef TROS_SEQ_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    tros_meas_sequencer #(
        .CLEAR_CYCLES     (2),
        .WINDOW_BASE_LOG2 (4),
        .SETTLE_CYCLES    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .window_sel (window_sel),
        .ctr_reset  (ctr_reset),
        .gate       (gate),
        .latch      (latch),
        .busy       (busy),
        .done       (done),
        .meas_count (meas_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int gate_cnt, gate_first, gate_last, ctr_cnt, ctr_first;
    int done_cnt, busy_cnt, nlat, nruns, cur_run;
    int lat_cyc [0:7];
    int runs [0:7];
    logic gate_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        gate_cnt = 0; gate_first = -1; gate_last = -1;
        ctr_cnt = 0; ctr_first = -1;
        done_cnt = 0; busy_cnt = 0; nlat = 0; nruns = 0; cur_run = 0;
        gate_prev = gate;
        for (int i = 0; i < 8; i++) begin
            lat_cyc[i] = -1;
            runs[i] = -1;
        end
    endtask

    // Advance one cycle and record the outputs of the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (gate) begin
            gate_cnt++;
            if (gate_first < 0) gate_first = cyc;
            gate_last = cyc;
            cur_run++;
        end else if (gate_prev) begin
            if (nruns < 8) runs[nruns] = cur_run;
            nruns++;
            cur_run = 0;
        end
        gate_prev = gate;
        if (ctr_reset) begin
            ctr_cnt++;
            if (ctr_first < 0) ctr_first = cyc;
        end
        if (latch) begin
            if (nlat < 8) lat_cyc[nlat] = cyc;
            nlat++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_gate(input int target, input string tag);
        int n;
        n = 0;
        while (gate_cnt < target && n < 5000) begin
            step();
            n++;
        end
        chk(tag, gate_cnt, target);
    endtask

    task automatic wait_latch(input int target, input string tag);
        int n;
        n = 0;
        while (nlat < target && n < 5000) begin
            step();
            n++;
        end
        chk(tag, nlat, target);
    endtask

    initial begin
        int s;

        // Reset state
        repeat (3) step();
        chk("rst_ctr_reset", {31'd0, ctr_reset}, 0);
        chk("rst_gate",      {31'd0, gate}, 0);
        chk("rst_latch",     {31'd0, latch}, 0);
        chk("rst_done",      {31'd0, done}, 0);
        chk("rst_busy",      {31'd0, busy}, 0);
        chk("rst_count",     {16'd0, meas_count}, 0);
        chk("rst_overrun",   {31'd0, overrun}, 0);
        reset = 1'b0;
        cyc = 0;
        clear_stats();

        // Basic measurement, start during cycle 10
        while (cyc < 10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle("basic_timeout");
        chk("basic_idle_cycle", cyc, 33);
        chk("basic_ctr_first",  ctr_first, 11);
        chk("basic_ctr_len",    ctr_cnt, 2);
        chk("basic_gate_first", gate_first, 13);
        chk("basic_gate_last",  gate_last, 28);
        chk("basic_gate_len",   gate_cnt, 16);
        chk("basic_latch_cyc",  lat_cyc[0], 32);
        chk("basic_latch_cnt",  nlat, 1);
        chk("basic_done_cnt",   done_cnt, 1);
        chk("basic_busy_len",   busy_cnt, 22);
        chk("basic_count",      {16'd0, meas_count}, 1);

        // Abort on the 5th gate cycle
        repeat (3) step();
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_gate(5, "abort_gate_timeout");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_gate",      {31'd0, gate}, 0);
        chk("abort_busy",      {31'd0, busy}, 0);
        chk("abort_ctr_reset", {31'd0, ctr_reset}, 0);
        repeat (25) step();
        chk("abort_no_latch",  nlat, 0);
        chk("abort_no_done",   done_cnt, 0);
        chk("abort_count",     {16'd0, meas_count}, 1);

        // ena low for 7 cycles mid-gate
        clear_stats();
        s = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_gate(5, "freeze_gate_timeout");
        ena = 1'b0;
        repeat (7) step();
        chk("freeze_gate_held", {31'd0, gate}, 1);
        ena = 1'b1;
        wait_idle("freeze_timeout");
        chk("freeze_gate_len",   gate_cnt, 23);
        chk("freeze_latch_ofs",  lat_cyc[0] - s, 29);
        chk("freeze_latch_cnt",  nlat, 1);
        chk("freeze_count",      {16'd0, meas_count}, 2);

        // start re-asserted during SETTLE
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_gate(16, "ovr_gate_timeout");
        step();
        chk("ovr_in_settle", {30'd0, gate, busy}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle("ovr_timeout");
        repeat (10) step();
        chk("ovr_one_latch", nlat, 1);
        chk("ovr_busy",      {31'd0, busy}, 0);
        chk("ovr_count",     {16'd0, meas_count}, 3);
        chk("ovr_flag",      {31'd0, overrun}, {31'd0, OVR_EXP});
        ena = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ena = 1'b1;
        chk("ovr_rst_flag",  {31'd0, overrun}, 0);
        chk("ovr_rst_count", {16'd0, meas_count}, 0);

        // start with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy",      {31'd0, busy}, 0);
        chk("sa_ctr_reset", {31'd0, ctr_reset}, 0);

        // Continuous, window_sel=3, window_sel wiggled during gate
        clear_stats();
        window_sel = 2'd3;
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_gate(100, "cont_g100_timeout");
        window_sel = 2'd0;
        wait_gate(300, "cont_g300_timeout");
        window_sel = 2'd3;
        wait_latch(3, "cont_latch_timeout");
        continuous = 1'b0;
        step();
        chk("cont_stop_busy", {31'd0, busy}, 0);
        chk("cont_run0",      runs[0], 1024);
        chk("cont_run1",      runs[1], 1024);
        chk("cont_run2",      runs[2], 1024);
        chk("cont_period1",   lat_cyc[1] - lat_cyc[0], 1030);
        chk("cont_period2",   lat_cyc[2] - lat_cyc[1], 1030);
        chk("cont_count",     {16'd0, meas_count}, 3);

        // abort beats continuous in LATCH
        clear_stats();
        window_sel = 2'd0;
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_latch(1, "lprio_latch_timeout");
        abort = 1'b1;
        step();
        abort = 1'b0;
        continuous = 1'b0;
        chk("lprio_busy",      {31'd0, busy}, 0);
        chk("lprio_ctr_reset", {31'd0, ctr_reset}, 0);
        chk("lprio_count",     {16'd0, meas_count}, 4);

        // meas_count wrap
        repeat (2) step();
        force dut.meas_count = 16'hFFFF;
        step();
        release dut.meas_count;
        step();
        chk("wrap_preload", {16'd0, meas_count}, 32'hFFFF);
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle("wrap_timeout");
        chk("wrap_latch_cnt", nlat, 1);
        chk("wrap_count",     {16'd0, meas_count}, 0);

        // Reset mid-gate
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_gate(3, "rmid_gate_timeout");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_gate", {31'd0, gate}, 0);
        chk("rmid_busy", {31'd0, busy}, 0);
        repeat (25) step();
        chk("rmid_no_latch", nlat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
